// File: rtl/traffic_phase_timer.sv
// Phase-duration timer feeding the traffic light FSM: tick prescaler, per-phase tick count, advance pulse.
// Optional pedestrian shortening of GREEN is enabled with `define TRAFFIC_PED_REQ_EN.
module traffic_phase_timer #(
    parameter int unsigned TICK_DIV    = 4,
    parameter int unsigned RED_TIME    = 5,
    parameter int unsigned YELLOW_TIME = 2,
    parameter int unsigned GREEN_TIME  = 5,
    parameter int unsigned MIN_GREEN   = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
`ifdef TRAFFIC_PED_REQ_EN
    input  logic             ped_req,
    output logic             ped_pending,
`endif
    output logic             advance,
    output logic [2:0]       phase,
    output logic             tick,
    output logic [CNT_W-1:0] remaining
);

    // Zero durations are promoted to one tick so every phase is visible downstream.
    localparam int unsigned RED_D  = (RED_TIME == 0)    ? 1 : RED_TIME;
    localparam int unsigned YEL_D  = (YELLOW_TIME == 0) ? 1 : YELLOW_TIME;
    localparam int unsigned GRN_D  = (GREEN_TIME == 0)  ? 1 : GREEN_TIME;
    localparam int unsigned MING_D = (MIN_GREEN == 0)   ? 1 : MIN_GREEN;
    localparam int unsigned PED_D  = (MING_D < GRN_D)   ? MING_D : GRN_D;

    typedef enum logic [2:0] {
        RED    = 3'b001,
        YELLOW = 3'b010,
        GREEN  = 3'b100
    } phase_t;

    phase_t           state, state_nxt, succ;
    logic [CNT_W-1:0] presc, presc_nxt;
    logic [CNT_W-1:0] elapsed, elapsed_nxt;
    logic [CNT_W-1:0] remaining_nxt, dur_cur, dur_nxt;
    logic             tick_nxt, advance_nxt;
    logic             ped_q, ped_nxt;

    function automatic logic [CNT_W-1:0] dur_of(input phase_t ph, input logic ped);
        case (ph)
            YELLOW:  dur_of = CNT_W'(YEL_D);
            GREEN:   dur_of = ped ? CNT_W'(PED_D) : CNT_W'(GRN_D);
            default: dur_of = CNT_W'(RED_D);
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RED;
            presc     <= '0;
            elapsed   <= '0;
            tick      <= 1'b0;
            advance   <= 1'b0;
            remaining <= CNT_W'(RED_D);
            ped_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            presc     <= presc_nxt;
            elapsed   <= elapsed_nxt;
            tick      <= tick_nxt;
            advance   <= advance_nxt;
            remaining <= remaining_nxt;
            ped_q     <= ped_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        presc_nxt     = presc;
        elapsed_nxt   = elapsed;
        tick_nxt      = 1'b0;
        advance_nxt   = 1'b0;
        ped_nxt       = ped_q;
        dur_cur       = dur_of(state, ped_q);
        dur_nxt       = '0;
        remaining_nxt = '0;

        case (state)
            RED:     succ = YELLOW;
            YELLOW:  succ = GREEN;
            default: succ = RED;
        endcase

        if (!hold) begin
            if (presc == CNT_W'(TICK_DIV - 1)) begin
                presc_nxt = '0;
                tick_nxt  = 1'b1;
            end else begin
                presc_nxt = presc + CNT_W'(1);
            end
        end

        // ">=" lets a late pedestrian request end GREEN on the very next tick.
        if (!(state inside {RED, YELLOW, GREEN})) begin
            state_nxt   = RED;
            elapsed_nxt = '0;
        end else if (tick_nxt) begin
            if (elapsed >= dur_cur - CNT_W'(1)) begin
                state_nxt   = succ;
                elapsed_nxt = '0;
                advance_nxt = 1'b1;
            end else begin
                elapsed_nxt = elapsed + CNT_W'(1);
            end
        end

`ifdef TRAFFIC_PED_REQ_EN
        // A request on the GREEN->RED edge is dropped: the RED phase serves it.
        if (advance_nxt && state == GREEN) begin
            ped_nxt = 1'b0;
        end else if (ped_req) begin
            ped_nxt = 1'b1;
        end
`endif

        // Shortened GREEN may already be overrun; show one tick left in that case.
        dur_nxt       = dur_of(state_nxt, ped_nxt);
        remaining_nxt = (elapsed_nxt < dur_nxt) ? dur_nxt - elapsed_nxt : CNT_W'(1);
    end

    assign phase = state;
`ifdef TRAFFIC_PED_REQ_EN
    assign ped_pending = ped_q;
`endif

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Bench for traffic_phase_timer: segment table plus per-cycle scoreboard from a closed-form timing model.
// Pedestrian sequences run only when TRAFFIC_PED_REQ_EN is defined.
module tb_traffic_phase_timer;

    localparam int TD = 4;
    localparam int R  = 5;
    localparam int Y  = 2;
    localparam int G  = 5;

    logic       clk = 1'b0;
    logic       reset, hold, ped_req;
    logic       m_adv, m_tick, z_adv, z_tick;
    logic [2:0] m_ph, z_ph;
    logic [7:0] m_rem, z_rem;
    logic       m_ped, z_ped;

    always #5 clk = ~clk;

    traffic_phase_timer u_m (
        .clk(clk), .reset(reset), .hold(hold),
`ifdef TRAFFIC_PED_REQ_EN
        .ped_req(ped_req), .ped_pending(m_ped),
`endif
        .advance(m_adv), .phase(m_ph), .tick(m_tick), .remaining(m_rem)
    );

    traffic_phase_timer #(.YELLOW_TIME(0)) u_z (
        .clk(clk), .reset(reset), .hold(hold),
`ifdef TRAFFIC_PED_REQ_EN
        .ped_req(1'b0), .ped_pending(z_ped),
`endif
        .advance(z_adv), .phase(z_ph), .tick(z_tick), .remaining(z_rem)
    );

`ifndef TRAFFIC_PED_REQ_EN
    assign m_ped = 1'b0;
    assign z_ped = 1'b0;
`endif

    typedef struct {
        logic [2:0] ph;
        logic       adv;
        logic       tk;
        logic [7:0] rem;
    } exp_t;

    typedef struct {
        exp_t m;
        exp_t z;
    } pair_t;

    typedef struct {
        logic       rst;
        logic       hld;
        int         n;
        logic [2:0] ph;
        logic [7:0] rem;
        logic       adv;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    int    tcount = 0;
    bit    sb_on  = 1'b1;
    pair_t sbq[$];
    vec_t  vt[13];

    // Expected outputs from the count of running edges since reset, as a position within one full cycle.
    function automatic exp_t model(int tc, bit act, int r, int y, int g);
        exp_t e;
        int   len, p, t;
        len = (r + y + g) * TD;
        p   = tc % len;
        t   = p / TD;
        if (t < r) begin
            e.ph = 3'b001; e.rem = 8'(r - t);
        end else if (t < r + y) begin
            e.ph = 3'b010; e.rem = 8'(r + y - t);
        end else begin
            e.ph = 3'b100; e.rem = 8'(r + y + g - t);
        end
        e.tk  = act && (p % TD == 0);
        e.adv = act && (p == 0 || p == r * TD || p == (r + y) * TD);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        bit    act;
        pair_t pr;
        if (reset) begin
            tcount = 0; act = 1'b0;
        end else if (hold) begin
            act = 1'b0;
        end else begin
            tcount++; act = 1'b1;
        end
        if (sb_on) sbq.push_back('{model(tcount, act, R, Y, G), model(tcount, act, R, 1, G)});
        @(posedge clk);
        #1;
        if (sb_on) begin
            if (sbq.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                pr = sbq.pop_front();
                chk("m_phase", m_ph, pr.m.ph);
                chk("m_advance", m_adv, pr.m.adv);
                chk("m_tick", m_tick, pr.m.tk);
                chk("m_remaining", m_rem, pr.m.rem);
                chk("z_phase", z_ph, pr.z.ph);
                chk("z_advance", z_adv, pr.z.adv);
                chk("z_tick", z_tick, pr.z.tk);
                chk("z_remaining", z_rem, pr.z.rem);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic restart();
        reset = 1'b1; run(1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0; ped_req = 1'b0;

        vt[0]  = '{1'b1, 1'b0,  2, 3'b001, 8'd5, 1'b0};
        vt[1]  = '{1'b0, 1'b0, 20, 3'b010, 8'd2, 1'b1};
        vt[2]  = '{1'b0, 1'b0,  2, 3'b010, 8'd2, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 10, 3'b010, 8'd2, 1'b0};
        vt[4]  = '{1'b0, 1'b0,  6, 3'b100, 8'd5, 1'b1};
        vt[5]  = '{1'b0, 1'b0,  8, 3'b100, 8'd3, 1'b0};
        vt[6]  = '{1'b1, 1'b0,  1, 3'b001, 8'd5, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 19, 3'b001, 8'd1, 1'b0};
        vt[8]  = '{1'b0, 1'b0,  1, 3'b010, 8'd2, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 28, 3'b001, 8'd5, 1'b1};
        vt[10] = '{1'b0, 1'b0, 48, 3'b001, 8'd5, 1'b1};
        vt[11] = '{1'b1, 1'b1,  2, 3'b001, 8'd5, 1'b0};
        vt[12] = '{1'b0, 1'b1,  3, 3'b001, 8'd5, 1'b0};

        for (int v = 0; v < 13; v++) begin
            reset = vt[v].rst;
            hold  = vt[v].hld;
            run(vt[v].n);
            chk($sformatf("seg%0d_phase", v), m_ph, vt[v].ph);
            chk($sformatf("seg%0d_remaining", v), m_rem, vt[v].rem);
            chk($sformatf("seg%0d_advance", v), m_adv, vt[v].adv);
        end
        hold = 1'b0;

        // Zero-duration YELLOW: entered at edge 20, left at edge 24.
        restart();
        run(20);
        chk("zero_yellow_entry", z_ph, 3'b010);
        run(3);
        chk("zero_yellow_hold", z_ph, 3'b010);
        run(1);
        chk("zero_yellow_exit", z_ph, 3'b100);
        chk("zero_yellow_adv", z_adv, 1'b1);

`ifdef TRAFFIC_PED_REQ_EN
        sb_on = 1'b0;
        // Request right after GREEN entry: GREEN lasts 2 ticks.
        restart();
        run(28);
        chk("ped1_green_entry", m_ph, 3'b100);
        ped_req = 1'b1; run(1); ped_req = 1'b0;
        chk("ped1_pending_set", m_ped, 1'b1);
        chk("ped1_remaining", m_rem, 8'd2);
        run(6);
        chk("ped1_still_green", m_ph, 3'b100);
        run(1);
        chk("ped1_red", m_ph, 3'b001);
        chk("ped1_adv", m_adv, 1'b1);
        chk("ped1_pending_clr", m_ped, 1'b0);

        // Late request at elapsed 3: GREEN ends on the next tick.
        restart();
        run(40);
        ped_req = 1'b1; run(1); ped_req = 1'b0;
        chk("ped2_pending_set", m_ped, 1'b1);
        run(2);
        chk("ped2_still_green", m_ph, 3'b100);
        chk("ped2_no_adv", m_adv, 1'b0);
        run(1);
        chk("ped2_red", m_ph, 3'b001);
        chk("ped2_adv", m_adv, 1'b1);
        chk("ped2_pending_clr", m_ped, 1'b0);

        // Request on the GREEN->RED edge itself is dropped.
        restart();
        run(47);
        ped_req = 1'b1; run(1); ped_req = 1'b0;
        chk("ped3_red", m_ph, 3'b001);
        chk("ped3_adv", m_adv, 1'b1);
        chk("ped3_pending", m_ped, 1'b0);
        chk("ped3_z_pending", z_ped, 1'b0);
`else
        chk("noped_pending", m_ped | z_ped, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_phase_timer.md
# traffic_phase_timer

Phase-duration timer that sits directly upstream of the traffic light FSM and produces its one-cycle `advance` pulse. It divides `clk` into ticks, holds each phase (RED -> YELLOW -> GREEN -> RED) for a programmed number of ticks, and tracks the phase so that its count stays aligned with the downstream light sequence. Optionally, a pedestrian request shortens GREEN.

## Interface
- `TICK_DIV`, default 4: clk cycles per tick (>= 2).
- `RED_TIME`, default 5: RED duration in ticks.
- `YELLOW_TIME`, default 2: YELLOW duration in ticks.
- `GREEN_TIME`, default 5: GREEN duration in ticks.
- `MIN_GREEN`, default 2: shortened GREEN duration in ticks (pedestrian option only).
- `CNT_W`, default 8: width of the tick counters.
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `hold`, in, 1: freezes all timing while high.
- `ped_req`, in, 1: pedestrian request pulse; present only with `TRAFFIC_PED_REQ_EN`.
- `advance`, out, 1: one-cycle pulse at each phase change; drives the downstream FSM step.
- `phase`, out, 3: one-hot current phase (001 RED, 010 YELLOW, 100 GREEN).
- `tick`, out, 1: one-cycle pulse on each prescaler wrap.
- `remaining`, out, CNT_W: ticks left in the current phase, including the current tick.
- `ped_pending`, out, 1: latched pedestrian request; present only with `TRAFFIC_PED_REQ_EN`.

## Operation
- **Prescaler:** `presc` counts 0..TICK_DIV-1. A tick condition occurs on the edge where `presc == TICK_DIV-1` and `hold == 0`. On that edge `presc` wraps to 0 and registered `tick` is set for one cycle.
- **Elapsed counter:** `elapsed` counts ticks within the phase. The effective duration `dur` is RED_TIME, YELLOW_TIME or GREEN_TIME, selected by phase. A parameter value of 0 is treated as 1.
- **Phase change:**
  - On a tick with `elapsed == dur-1`: phase moves to the next state, `elapsed` goes to 0, and `advance` is set for one cycle.
  - On any other tick: `elapsed` increments.
- **Phase order:** RED -> YELLOW -> GREEN -> RED only. An illegal `phase` encoding recovers to RED on the next edge, with `elapsed` = 0 and no `advance`.
- **`remaining`:** registered, equal to `dur - elapsed` after every edge.
- **Hold:** while `hold` is high, `presc`, `elapsed` and `phase` are frozen, and `tick` and `advance` stay 0. Timing resumes from the frozen values.
- **Reset values:**
  - Outputs: `phase` = 001, `advance` = 0, `tick` = 0, `remaining` = RED_TIME, `ped_pending` = 0.
  - Internal: `presc` = 0, `elapsed` = 0.
  - Reset overrides `hold` and `ped_req`. Reset asserted mid-phase aborts the phase immediately with no `advance`.
- **Counter widths:** all counters are CNT_W bits. Parameters must be below 2^CNT_W; the counters never wrap within a phase.

## Timing
- All outputs are registered, so no output has a combinational path from an input.
- The first `advance` is high in the cycle after the (RED_TIME*TICK_DIV)-th non-hold edge following reset deassertion.
- `advance` coincides with a `tick` pulse and with the new `phase` value. `remaining` shows the new phase's duration in the same cycle.
- One full cycle with no hold takes (RED_TIME+YELLOW_TIME+GREEN_TIME)*TICK_DIV clk cycles.
- `advance` is never high on two consecutive cycles.

## Configuration
- **Macro:** `TRAFFIC_PED_REQ_EN`.
- **When defined:**
  - The `ped_req` and `ped_pending` ports exist.
  - `ped_req` high on any non-reset edge sets `ped_pending`. Setting happens even during `hold`.
  - While GREEN and `ped_pending` are both true, `dur` = min(GREEN_TIME, MIN_GREEN).
  - If a request arrives when `elapsed` is already >= `dur-1`, GREEN ends on the next tick.
  - `ped_pending` clears on the edge where GREEN -> RED `advance` fires.
  - A `ped_req` arriving on that same edge is dropped, because RED serves it.
- **When undefined:**
  - Neither port exists.
  - GREEN always lasts GREEN_TIME.
  - The logic is identical otherwise.

## Test plan
- **Reset sequence (defaults):** release reset, run 48 cycles -> `advance` pulses at cycles 20, 28 and 48; `phase` goes 001 -> 010 -> 100 -> 001; `tick` pulses every 4 cycles.
- **Hold:** assert `hold` for 10 cycles in mid-YELLOW -> `phase`, `remaining` and `presc` are frozen with no tick; the next `advance` is delayed exactly 10 cycles.
- **Reset mid-GREEN** (`remaining` = 3) -> next cycle shows `phase` = 001, `remaining` = 5, `advance` = 0; the next `advance` comes 20 cycles after reset release.
- **Zero duration** (YELLOW_TIME = 0) -> YELLOW lasts exactly 1 tick (4 cycles).
- **Pedestrian request at GREEN entry** (`TRAFFIC_PED_REQ_EN`): `ped_req` pulse -> GREEN lasts 2 ticks (8 cycles); `ped_pending` clears with the GREEN -> RED `advance`.
- **Late pedestrian request** (`TRAFFIC_PED_REQ_EN`): `ped_req` at GREEN `elapsed` = 3 -> `advance` on the next tick. Separately, a `ped_req` on the GREEN -> RED edge -> `ped_pending` stays 0.
